// File: rtl/output_port_stage_pkg.sv
// Shared types and sizing for the router output-port stage.
package output_port_stage_pkg;

    localparam int VC_NUM    = 4;
    localparam int VC_W      = $clog2(VC_NUM);
    localparam int DATA_W    = 16;
    localparam int OFF_SLACK = 2;

    typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

    typedef struct packed {
        flit_label_t       label;
        logic [VC_W-1:0]   vc_id;
        logic [DATA_W-1:0] data;
    } flit_t;

    typedef enum logic [1:0] {FREE, RESERVED, ACTIVE} out_vc_state_t;

    // True when more than one bit is set.
    function automatic logic multi_hot(input logic [VC_NUM-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

endpackage

// File: rtl/output_port_stage_if.sv
// Crossbar-side, link-side and allocator-side signals of one output port.
interface output_port_stage_if;
    import output_port_stage_pkg::*;

    flit_t             xb_flit_i;
    logic              xb_valid_i;
    logic [VC_NUM-1:0] on_off_i;
    logic [VC_NUM-1:0] vc_allocatable_i;
    logic [VC_NUM-1:0] va_grant_i;
    flit_t             link_flit_o;
    logic              link_valid_o;
    logic [VC_NUM-1:0] sa_ready_o;
    logic [VC_NUM-1:0] va_available_o;
    logic [VC_NUM-1:0] error_o;

    modport master (
        output xb_flit_i, xb_valid_i, on_off_i, vc_allocatable_i, va_grant_i,
        input  link_flit_o, link_valid_o, sa_ready_o, va_available_o, error_o
    );

    modport slave (
        input  xb_flit_i, xb_valid_i, on_off_i, vc_allocatable_i, va_grant_i,
        output link_flit_o, link_valid_o, sa_ready_o, va_available_o, error_o
    );

endinterface

// File: rtl/output_port_stage_vc_tracker.sv
// One downstream VC: FREE/RESERVED/ACTIVE tracking, off-slack counter and sticky error.
module out_vc_tracker
    import output_port_stage_pkg::*;
#(
    parameter int SLACK = OFF_SLACK
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flit_hit_i,
    input  flit_label_t label_i,
    input  logic        grant_i,
    input  logic        multi_grant_i,
    input  logic        on_i,
    input  logic        alloc_i,
    output logic        sa_ready_o,
    output logic        va_available_o,
    output logic        error_o
);

    localparam int               CNT_W   = $clog2(SLACK + 2);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(SLACK);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLACK + 1);

    out_vc_state_t    state_q, state_d, state_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d, ev_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FREE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        state_nxt = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ev_err    = 1'b0;

        if (grant_i) begin
            if (multi_grant_i || state_q != FREE) ev_err = 1'b1;
            else                                  state_nxt = RESERVED;
        end

        if (flit_hit_i) begin
            if (!on_i && cnt_q >= CNT_LIM) ev_err = 1'b1;
            case (state_q)
                RESERVED: begin
                    if (label_i == HEAD)          state_nxt = ACTIVE;
                    else if (label_i == HEADTAIL) state_nxt = FREE;
                    else                          ev_err = 1'b1;
                end
                ACTIVE: begin
                    if (label_i == TAIL)          state_nxt = FREE;
                    else if (label_i != BODY)     ev_err = 1'b1;
                end
                default: ev_err = 1'b1;
            endcase
        end

        // An offending event leaves the state where it was; an errored VC is frozen.
        if (ev_err)      err_d   = 1'b1;
        else if (!err_q) state_d = state_nxt;

        if (on_i)                            cnt_d = '0;
        else if (flit_hit_i && cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end

    assign va_available_o = (state_q == FREE) & alloc_i & ~err_q;
    assign sa_ready_o     = on_i & (state_q != FREE) & ~err_q;
    assign error_o        = err_q;

endmodule

// File: rtl/output_port_stage.sv
// Output port stage: link register, downstream status capture and per-VC trackers.
module output_port_stage
    import output_port_stage_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    output_port_stage_if.slave  port
);

    logic [VC_NUM-1:0] on_q, alloc_q;
    flit_t             link_flit_q;
    logic              link_valid_q;
    logic [VC_NUM-1:0] flit_hit, sa_ready, va_avail, err;
    logic              multi_grant;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            on_q         <= '0;
            alloc_q      <= '0;
            link_flit_q  <= '0;
            link_valid_q <= 1'b0;
        end else begin
            on_q         <= port.on_off_i;
            alloc_q      <= port.vc_allocatable_i;
            link_valid_q <= port.xb_valid_i;
            if (port.xb_valid_i) link_flit_q <= port.xb_flit_i;
        end
    end

    assign multi_grant = multi_hot(port.va_grant_i);

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        assign flit_hit[v] = port.xb_valid_i && (port.xb_flit_i.vc_id == VC_W'(v));

        out_vc_tracker #(.SLACK(OFF_SLACK)) u_trk (
            .clk            (clk),
            .rst_n          (rst_n),
            .flit_hit_i     (flit_hit[v]),
            .label_i        (port.xb_flit_i.label),
            .grant_i        (port.va_grant_i[v]),
            .multi_grant_i  (multi_grant),
            .on_i           (on_q[v]),
            .alloc_i        (alloc_q[v]),
            .sa_ready_o     (sa_ready[v]),
            .va_available_o (va_avail[v]),
            .error_o        (err[v])
        );
    end

    assign port.link_flit_o    = link_flit_q;
    assign port.link_valid_o   = link_valid_q;
    assign port.sa_ready_o     = sa_ready;
    assign port.va_available_o = va_avail;
    assign port.error_o        = err;

endmodule

// File: tb/tb_output_port_stage.sv
// Directed and random stimulus for output_port_stage against a per-VC packet model.
module tb_output_port_stage;
    import output_port_stage_pkg::*;

    localparam int M_FREE = 0, M_RES = 1, M_ACT = 2;
    localparam int L_HEAD = 0, L_BODY = 1, L_TAIL = 2, L_HT = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    output_port_stage_if ifc ();
    output_port_stage dut (.clk(clk), .rst_n(rst_n), .port(ifc));

    int total = 0;
    int bad   = 0;

    // Model: what each VC is doing, plus last-seen downstream status.
    int                st  [VC_NUM];
    bit                err [VC_NUM];
    int                cnt [VC_NUM];
    bit                m_on[VC_NUM];
    bit                m_al[VC_NUM];
    bit                e_valid;
    logic [31:0]       e_flit;
    logic [VC_NUM-1:0] on_v, alloc_v;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < VC_NUM; v++) begin
            st[v] = M_FREE; err[v] = 0; cnt[v] = 0; m_on[v] = 0; m_al[v] = 0;
        end
        e_valid = 0;
        e_flit  = '0;
    endtask

    task automatic model_step();
        int ng, lab, vc, nx;
        bit e, hit;
        ng  = $countones(ifc.va_grant_i);
        lab = int'(ifc.xb_flit_i.label);
        vc  = int'(ifc.xb_flit_i.vc_id);
        for (int v = 0; v < VC_NUM; v++) begin
            e   = 0;
            nx  = st[v];
            hit = ifc.xb_valid_i && (vc == v);
            if (ifc.va_grant_i[v]) begin
                if (ng > 1 || st[v] != M_FREE) e = 1;
                else nx = M_RES;
            end
            if (hit) begin
                if (!m_on[v] && cnt[v] >= OFF_SLACK) e = 1;
                if (st[v] == M_FREE) e = 1;
                else if (st[v] == M_RES) begin
                    if (lab == L_HEAD) nx = M_ACT;
                    else if (lab == L_HT) nx = M_FREE;
                    else e = 1;
                end else begin
                    if (lab == L_TAIL) nx = M_FREE;
                    else if (lab != L_BODY) e = 1;
                end
            end
            if (e) err[v] = 1;
            else if (!err[v]) st[v] = nx;
            if (m_on[v]) cnt[v] = 0;
            else if (hit && cnt[v] < OFF_SLACK + 1) cnt[v]++;
            m_on[v] = ifc.on_off_i[v];
            m_al[v] = ifc.vc_allocatable_i[v];
        end
        e_valid = ifc.xb_valid_i;
        if (ifc.xb_valid_i) e_flit = 32'(ifc.xb_flit_i);
    endtask

    task automatic check_all();
        logic [VC_NUM-1:0] ev_sa, ev_va, ev_er;
        for (int v = 0; v < VC_NUM; v++) begin
            ev_er[v] = err[v];
            ev_va[v] = (st[v] == M_FREE) && m_al[v] && !err[v];
            ev_sa[v] = m_on[v] && (st[v] != M_FREE) && !err[v];
        end
        chk("link_valid", 32'(ifc.link_valid_o), 32'(e_valid));
        chk("link_flit", 32'(ifc.link_flit_o), e_flit);
        chk("sa_ready", 32'(ifc.sa_ready_o), 32'(ev_sa));
        chk("va_available", 32'(ifc.va_available_o), 32'(ev_va));
        chk("error", 32'(ifc.error_o), 32'(ev_er));
    endtask

    task automatic cycle(input bit valid, input int lab, input int vc, input logic [VC_NUM-1:0] g);
        ifc.xb_valid_i       = valid;
        ifc.xb_flit_i        = '{label: flit_label_t'(2'(lab)), vc_id: VC_W'(vc), data: DATA_W'($urandom)};
        ifc.va_grant_i       = g;
        ifc.on_off_i         = on_v;
        ifc.vc_allocatable_i = alloc_v;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        ifc.xb_valid_i = 1'b0;
        ifc.va_grant_i = '0;
    endtask

    task automatic idle();
        cycle(0, L_BODY, 0, '0);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_rst_valid"}, 32'(ifc.link_valid_o), 32'd0);
        chk({tag, "_rst_flit"}, 32'(ifc.link_flit_o), 32'd0);
        chk({tag, "_rst_sa"}, 32'(ifc.sa_ready_o), 32'd0);
        chk({tag, "_rst_va"}, 32'(ifc.va_available_o), 32'd0);
        chk({tag, "_rst_err"}, 32'(ifc.error_o), 32'd0);
        model_reset();
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int r, vc, lab;
        logic [VC_NUM-1:0] g;
        ifc.xb_valid_i = 0; ifc.xb_flit_i = '0; ifc.va_grant_i = '0;
        on_v = '1; alloc_v = '1;
        ifc.on_off_i = on_v; ifc.vc_allocatable_i = alloc_v;
        model_reset();
        #22 rst_n = 1'b1;

        // Packet on VC1: grant, HEAD, BODY, TAIL.
        idle();
        chk("t2_va_init", 32'(ifc.va_available_o), 32'hF);
        cycle(0, L_HEAD, 0, 4'b0010);
        chk("t2_va1_granted", 32'(ifc.va_available_o[1]), 32'd0);
        chk("t2_sa1_granted", 32'(ifc.sa_ready_o[1]), 32'd1);
        cycle(1, L_HEAD, 1, '0);
        chk("t2_head_link", 32'(ifc.link_valid_o), 32'd1);
        cycle(1, L_BODY, 1, '0);
        chk("t2_va1_mid", 32'(ifc.va_available_o[1]), 32'd0);
        cycle(1, L_TAIL, 1, '0);
        chk("t2_va1_after_tail", 32'(ifc.va_available_o[1]), 32'd1);
        idle();
        chk("t2_link_idle", 32'(ifc.link_valid_o), 32'd0);

        // HEADTAIL on VC0.
        cycle(0, L_HEAD, 0, 4'b0001);
        cycle(1, L_HT, 0, '0);
        chk("t3_err0", 32'(ifc.error_o[0]), 32'd0);
        chk("t3_va0", 32'(ifc.va_available_o[0]), 32'd1);

        // BODY on a FREE VC2.
        cycle(1, L_BODY, 2, '0);
        chk("t4_err", 32'(ifc.error_o), 32'h4);
        idle(); idle();
        chk("t4_err_sticky", 32'(ifc.error_o[2]), 32'd1);
        chk("t4_va2", 32'(ifc.va_available_o[2]), 32'd0);
        cycle(0, L_HEAD, 0, 4'b0100);
        chk("t4_sa2_after_grant", 32'(ifc.sa_ready_o[2]), 32'd0);

        // Slack on VC3 while its on_off is low.
        cycle(0, L_HEAD, 0, 4'b1000);
        cycle(1, L_HEAD, 3, '0);
        on_v[3] = 1'b0;
        idle();
        cycle(1, L_BODY, 3, '0);
        cycle(1, L_BODY, 3, '0);
        chk("t5_two_ok", 32'(ifc.error_o[3]), 32'd0);
        cycle(1, L_BODY, 3, '0);
        chk("t5_third_err", 32'(ifc.error_o[3]), 32'd1);
        on_v[3] = 1'b1;
        idle(); idle();
        chk("t5_sa3_stays0", 32'(ifc.sa_ready_o[3]), 32'd0);

        // TAIL and grant on VC1 together, then reset mid-packet.
        cycle(0, L_HEAD, 0, 4'b0010);
        cycle(1, L_HEAD, 1, '0);
        cycle(1, L_TAIL, 1, 4'b0010);
        chk("t6_collision_err", 32'(ifc.error_o[1]), 32'd1);
        cycle(0, L_HEAD, 0, 4'b0001);
        cycle(1, L_HEAD, 0, '0);
        cycle(1, L_BODY, 0, '0);
        do_reset("t1");
        idle();
        chk("t1_va_after_rst", 32'(ifc.va_available_o), 32'(alloc_v));

        // Grant one cycle after the TAIL instead.
        cycle(0, L_HEAD, 0, 4'b0010);
        cycle(1, L_HEAD, 1, '0);
        cycle(1, L_TAIL, 1, '0);
        cycle(0, L_HEAD, 0, 4'b0010);
        chk("t6_regrant_err", 32'(ifc.error_o[1]), 32'd0);
        chk("t6_regrant_sa", 32'(ifc.sa_ready_o[1]), 32'd1);
        chk("t6_regrant_va", 32'(ifc.va_available_o[1]), 32'd0);

        // Not one-hot grant flags every granted VC.
        cycle(0, L_HEAD, 0, 4'b0101);
        chk("multi_grant_err", 32'(ifc.error_o & 4'b0101), 32'h5);

        // Random traffic, biased toward legal packet sequences.
        for (int round = 0; round < 4; round++) begin
            do_reset("rnd");
            for (int n = 0; n < 150; n++) begin
                for (int v = 0; v < VC_NUM; v++) begin
                    on_v[v]    = ($urandom_range(0, 7) != 0);
                    alloc_v[v] = ($urandom_range(0, 3) != 0);
                end
                g = '0;
                r = $urandom_range(0, 19);
                if (r < 4) g[$urandom_range(0, VC_NUM - 1)] = 1'b1;
                else if (r == 4) g = VC_NUM'($urandom);
                vc = $urandom_range(0, VC_NUM - 1);
                if ($urandom_range(0, 19) == 0) lab = $urandom_range(0, 3);
                else if (st[vc] == M_RES) lab = ($urandom_range(0, 3) == 0) ? L_HT : L_HEAD;
                else lab = ($urandom_range(0, 3) == 0) ? L_TAIL : L_BODY;
                cycle(($urandom_range(0, 9) < 6) && st[vc] != M_FREE, lab, vc, g);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
